// File: rtl/score_combo_tracker.sv
// Score / combo / life tracker for the play field, with a scanned 4-digit BCD score readout.
module score_combo_tracker #(
    parameter int unsigned LIFE_MAX   = 10,
    parameter int unsigned COMBO_STEP = 10,
    parameter int unsigned MULT_MAX   = 4,
    parameter int unsigned SCAN_BIT   = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit,
    input  logic        damage,
    input  logic [3:0]  state,
    output logic [9:0]  life,
    output logic        fail,
    output logic [7:0]  combo,
    output logic [15:0] score,
    output logic [6:0]  display,
    output logic [3:0]  digit
);

    localparam int unsigned LIFE_W = 4;
    localparam int unsigned CNT_W  = SCAN_BIT + 1;
    localparam logic [9:0]  LIFE_FULL = 10'((32'd1 << LIFE_MAX) - 32'd1);
    localparam logic [3:0]  ST_GAMESTART = 4'd0;

    logic [3:0]        prev_state;
    logic [LIFE_W-1:0] life_cnt;
    logic [LIFE_W-1:0] life_cnt_next;
    logic [7:0]        combo_next;
    logic [15:0]       score_next;
    logic [CNT_W-1:0]  scan_cnt;
    logic [CNT_W-1:0]  scan_cnt_next;
    logic [1:0]        sel_next;
    logic [7:0]        tier;
    logic [3:0]        mult;
    logic              playing;
    logic              game_start;

    // BCD increment by a single digit with ripple carry; overflow past 9999 saturates.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] s, input logic [3:0] inc);
        logic [4:0]  carry;
        logic [4:0]  d;
        logic [15:0] r;
        carry = {1'b0, inc};
        r     = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            d = 5'(s[i*4 +: 4]) + carry;
            if (d > 5'd9) begin
                r[i*4 +: 4] = 4'(d - 5'd10);
                carry       = 5'd1;
            end else begin
                r[i*4 +: 4] = 4'(d);
                carry       = 5'd0;
            end
        end
        bcd_add_sat = (carry != 5'd0) ? 16'h9999 : r;
    endfunction

    // Thermometer code: bit i lit while i < count.
    function automatic logic [9:0] thermo(input logic [LIFE_W-1:0] cnt);
        for (int i = 0; i < 10; i++) begin
            thermo[i] = (i < int'(cnt));
        end
    endfunction

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles blank.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Multiplier from the pre-update combo, plus play/start decode.
    always_comb begin
        playing    = (state >= 4'd1) && (state <= 4'd4);
        game_start = (prev_state == ST_GAMESTART) && playing;
        tier       = combo / 8'(COMBO_STEP);
        if (tier > 8'(MULT_MAX - 1)) begin
            tier = 8'(MULT_MAX - 1);
        end
        mult = 4'(tier) + 4'd1;
    end

    // Next values of the game counters; non-playing codes other than GAMESTART freeze everything.
    always_comb begin
        life_cnt_next = life_cnt;
        combo_next    = combo;
        score_next    = score;
        if (state == ST_GAMESTART) begin
            life_cnt_next = LIFE_W'(LIFE_MAX);
            combo_next    = 8'd0;
        end else if (game_start) begin
            life_cnt_next = LIFE_W'(LIFE_MAX);
            combo_next    = 8'd0;
            score_next    = 16'h0000;
        end else if (playing) begin
            if (hit) begin
                score_next = bcd_add_sat(score, mult);
            end
            if (damage) begin
                combo_next = 8'd0;
                if (life_cnt != '0) begin
                    life_cnt_next = life_cnt - LIFE_W'(1);
                end
            end else if (hit && (combo != 8'hFF)) begin
                combo_next = combo + 8'd1;
            end
        end
    end

    // Scan select taken from the next counter value so digit and display move together.
    always_comb begin
        scan_cnt_next = scan_cnt + CNT_W'(1);
        sel_next      = scan_cnt_next[SCAN_BIT -: 2];
    end

    // Game state registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state <= ST_GAMESTART;
            life_cnt   <= LIFE_W'(LIFE_MAX);
            life       <= LIFE_FULL;
            combo      <= 8'd0;
            score      <= 16'h0000;
            fail       <= 1'b0;
        end else begin
            prev_state <= state;
            life_cnt   <= life_cnt_next;
            life       <= thermo(life_cnt_next);
            combo      <= combo_next;
            score      <= score_next;
            fail       <= (life_cnt_next == '0) && (state != ST_GAMESTART);
        end
    end

    // Free-running scan counter driving the digit/segment outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            digit    <= 4'b1110;
            display  <= 7'b1000000;
        end else begin
            scan_cnt <= scan_cnt_next;
            digit    <= ~(4'b0001 << sel_next);
            display  <= seg7(score_next[sel_next*4 +: 4]);
        end
    end

endmodule

// File: tb/tb_score_combo_tracker.sv
// Directed bench for score_combo_tracker (fast scan: SCAN_BIT=3).
module tb_score_combo_tracker;

    logic        clk;
    logic        rst;
    logic        hit;
    logic        damage;
    logic [3:0]  state;
    logic [9:0]  life;
    logic        fail;
    logic [7:0]  combo;
    logic [15:0] score;
    logic [6:0]  display;
    logic [3:0]  digit;

    int n_vec;
    int n_err;

    score_combo_tracker #(
        .LIFE_MAX(10), .COMBO_STEP(10), .MULT_MAX(4), .SCAN_BIT(3)
    ) dut (
        .clk(clk), .rst(rst), .hit(hit), .damage(damage), .state(state),
        .life(life), .fail(fail), .combo(combo), .score(score),
        .display(display), .digit(digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_state(input logic [3:0] s);
        @(negedge clk);
        state = s;
        @(negedge clk);
    endtask

    task automatic pulse(input logic h, input logic d);
        @(negedge clk);
        hit    = h;
        damage = d;
        @(negedge clk);
        hit    = 1'b0;
        damage = 1'b0;
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) pulse(1'b1, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1; hit = 1'b0; damage = 1'b0; state = 4'd0;
        repeat (2) @(negedge clk);
        n_vec++; if (life !== 10'h3FF) begin n_err++; $display("FAIL reset_life got=%h exp=3ff", life); end
        n_vec++; if (score !== 16'h0000) begin n_err++; $display("FAIL reset_score got=%h exp=0000", score); end
        n_vec++; if (combo !== 8'd0) begin n_err++; $display("FAIL reset_combo got=%0d exp=0", combo); end
        n_vec++; if (fail !== 1'b0) begin n_err++; $display("FAIL reset_fail got=%b exp=0", fail); end
        n_vec++; if (digit !== 4'b1110) begin n_err++; $display("FAIL reset_digit got=%b exp=1110", digit); end
        n_vec++; if (display !== 7'b1000000) begin n_err++; $display("FAIL reset_display got=%b exp=1000000", display); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_hits;
        set_state(4'd1);
        hits(12);
        n_vec++; if (combo !== 8'd12) begin n_err++; $display("FAIL hits_combo got=%0d exp=12", combo); end
        n_vec++; if (score !== 16'h0014) begin n_err++; $display("FAIL hits_score got=%h exp=0014", score); end
        n_vec++; if (life !== 10'h3FF) begin n_err++; $display("FAIL hits_life got=%h exp=3ff", life); end
    endtask

    // Score is 0014 here: ones='4', tens='1', hundreds/thousands='0'.
    task automatic test_scan;
        logic [3:0] prev_dig;
        logic [3:0] exp_next;
        logic [6:0] exp_seg;
        int         steps;
        prev_dig = digit;
        steps    = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            case (digit)
                4'b1110: exp_seg = 7'b0011001;
                4'b1101: exp_seg = 7'b1111001;
                default: exp_seg = 7'b1000000;
            endcase
            n_vec++; if (display !== exp_seg) begin n_err++; $display("FAIL scan_display digit=%b got=%b exp=%b", digit, display, exp_seg); end
            if (digit !== prev_dig) begin
                case (prev_dig)
                    4'b1110: exp_next = 4'b1101;
                    4'b1101: exp_next = 4'b1011;
                    4'b1011: exp_next = 4'b0111;
                    default: exp_next = 4'b1110;
                endcase
                n_vec++; if (digit !== exp_next) begin n_err++; $display("FAIL scan_order prev=%b got=%b exp=%b", prev_dig, digit, exp_next); end
                steps++;
                prev_dig = digit;
            end
        end
        n_vec++; if (steps < 8) begin n_err++; $display("FAIL scan_steps got=%0d exp>=8", steps); end
    endtask

    task automatic test_hit_damage;
        set_state(4'd0);
        set_state(4'd1);
        hits(9);
        n_vec++; if (score !== 16'h0009) begin n_err++; $display("FAIL hd_pre_score got=%h exp=0009", score); end
        pulse(1'b1, 1'b1);
        n_vec++; if (score !== 16'h0010) begin n_err++; $display("FAIL hd_score got=%h exp=0010", score); end
        n_vec++; if (combo !== 8'd0) begin n_err++; $display("FAIL hd_combo got=%0d exp=0", combo); end
        n_vec++; if (life !== 10'h1FF) begin n_err++; $display("FAIL hd_life got=%h exp=1ff", life); end
    endtask

    task automatic test_fail;
        set_state(4'd0);
        set_state(4'd1);
        for (int i = 0; i < 9; i++) pulse(1'b0, 1'b1);
        n_vec++; if (life !== 10'h001) begin n_err++; $display("FAIL fail9_life got=%h exp=001", life); end
        n_vec++; if (fail !== 1'b0) begin n_err++; $display("FAIL fail9_fail got=%b exp=0", fail); end
        pulse(1'b0, 1'b1);
        n_vec++; if (life !== 10'h000) begin n_err++; $display("FAIL fail10_life got=%h exp=000", life); end
        n_vec++; if (fail !== 1'b1) begin n_err++; $display("FAIL fail10_fail got=%b exp=1", fail); end
        pulse(1'b0, 1'b1);
        n_vec++; if (life !== 10'h000) begin n_err++; $display("FAIL fail11_life got=%h exp=000", life); end
        n_vec++; if (fail !== 1'b1) begin n_err++; $display("FAIL fail11_fail got=%b exp=1", fail); end
        pulse(1'b1, 1'b0);
        n_vec++; if (score !== 16'h0001) begin n_err++; $display("FAIL dead_hit_score got=%h exp=0001", score); end
        n_vec++; if (combo !== 8'd1) begin n_err++; $display("FAIL dead_hit_combo got=%0d exp=1", combo); end
    endtask

    task automatic test_freeze;
        set_state(4'd5);
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        n_vec++; if (score !== 16'h0001) begin n_err++; $display("FAIL frz_score got=%h exp=0001", score); end
        n_vec++; if (combo !== 8'd1) begin n_err++; $display("FAIL frz_combo got=%0d exp=1", combo); end
        n_vec++; if (fail !== 1'b1) begin n_err++; $display("FAIL frz_fail got=%b exp=1", fail); end
        n_vec++; if (life !== 10'h000) begin n_err++; $display("FAIL frz_life got=%h exp=000", life); end
        set_state(4'd0);
        n_vec++; if (fail !== 1'b0) begin n_err++; $display("FAIL gs_fail got=%b exp=0", fail); end
        n_vec++; if (life !== 10'h3FF) begin n_err++; $display("FAIL gs_life got=%h exp=3ff", life); end
        n_vec++; if (combo !== 8'd0) begin n_err++; $display("FAIL gs_combo got=%0d exp=0", combo); end
        n_vec++; if (score !== 16'h0001) begin n_err++; $display("FAIL gs_score got=%h exp=0001", score); end
        set_state(4'd2);
        n_vec++; if (score !== 16'h0000) begin n_err++; $display("FAIL start_score got=%h exp=0000", score); end
    endtask

    // 30 hits -> 60; 2464 more at x4 -> 9916; dmg,+2 -> 9918; dmg,35 hits (+80) -> 9998.
    task automatic test_saturate;
        hits(30);
        n_vec++; if (score !== 16'h0060) begin n_err++; $display("FAIL sat_ramp_score got=%h exp=0060", score); end
        hits(2464);
        n_vec++; if (score !== 16'h9916) begin n_err++; $display("FAIL sat_bulk_score got=%h exp=9916", score); end
        n_vec++; if (combo !== 8'd255) begin n_err++; $display("FAIL sat_combo255 got=%0d exp=255", combo); end
        pulse(1'b0, 1'b1);
        hits(2);
        pulse(1'b0, 1'b1);
        hits(35);
        n_vec++; if (score !== 16'h9998) begin n_err++; $display("FAIL sat_pre_score got=%h exp=9998", score); end
        n_vec++; if (combo !== 8'd35) begin n_err++; $display("FAIL sat_pre_combo got=%0d exp=35", combo); end
        pulse(1'b1, 1'b0);
        n_vec++; if (score !== 16'h9999) begin n_err++; $display("FAIL sat_score got=%h exp=9999", score); end
        n_vec++; if (combo !== 8'd36) begin n_err++; $display("FAIL sat_combo got=%0d exp=36", combo); end
        n_vec++; if (life !== 10'h0FF) begin n_err++; $display("FAIL sat_life got=%h exp=0ff", life); end
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        hit    = 1'b1;
        damage = 1'b1;
        rst    = 1'b1;
        #1;
        n_vec++; if (score !== 16'h0000) begin n_err++; $display("FAIL mrst_async_score got=%h exp=0000", score); end
        @(negedge clk);
        n_vec++; if (life !== 10'h3FF) begin n_err++; $display("FAIL mrst_life got=%h exp=3ff", life); end
        n_vec++; if (combo !== 8'd0) begin n_err++; $display("FAIL mrst_combo got=%0d exp=0", combo); end
        n_vec++; if (digit !== 4'b1110) begin n_err++; $display("FAIL mrst_digit got=%b exp=1110", digit); end
        hit    = 1'b0;
        damage = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_hits();
        test_scan();
        test_hit_damage();
        test_fail();
        test_freeze();
        test_saturate();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
